// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction-fetch stage: bus widths, read encoding,
// the default NOP word and the fetch FSM state encodings.
package if_fetch_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;

    localparam logic READ = 1'b1;

    localparam logic [DATA_W-1:0] NOP_INSN_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        FETCH_REQ    = 2'd0,
        FETCH_ACCESS = 2'd1,
        FETCH_HOLD   = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/if_fetch.sv
// Instruction-fetch stage: owns the PC, masters the bus and drives the IF/ID register.
// Define IF_INSN_BUF_EN to add a one-entry buffer that keeps a word fetched during stall.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [ADDR_W-1:0] RESET_VECTOR = 30'h0000_0000,
    parameter logic [DATA_W-1:0] NOP_INSN     = NOP_INSN_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic [ADDR_W-1:0] new_pc,
    input  logic              br_taken,
    input  logic [ADDR_W-1:0] br_addr,
    output logic              bus_req_,
    input  logic              bus_grnt_,
    output logic              bus_as_,
    output logic              bus_rw,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wr_data,
    input  logic [DATA_W-1:0] bus_rd_data,
    input  logic              bus_rdy_,
    output logic [ADDR_W-1:0] if_pc,
    output logic [DATA_W-1:0] if_insn,
    output logic              if_en,
    output logic              busy
);

    fetch_state_t      state;
    logic [ADDR_W-1:0] pc;
    logic              discard;
    logic              redirect;
    logic              complete;

`ifdef IF_INSN_BUF_EN
    logic [DATA_W-1:0] buf_insn;
`endif

    assign bus_rw      = READ;
    assign bus_wr_data = '0;

    // A redirect must not let a fresh access start from the stale PC.
    assign redirect = flush || (br_taken && !stall);
    assign complete = (state == FETCH_ACCESS) && !bus_rdy_;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= FETCH_REQ;
            pc       <= RESET_VECTOR;
            discard  <= 1'b0;
            if_pc    <= '0;
            if_insn  <= NOP_INSN;
            if_en    <= 1'b0;
            bus_req_ <= 1'b1;
            bus_as_  <= 1'b1;
            bus_addr <= '0;
            busy     <= 1'b0;
        end else begin
            bus_as_ <= 1'b1;
            case (state)
                FETCH_REQ: begin
                    bus_req_ <= 1'b0;
                    if (!bus_grnt_ && !redirect) begin
                        state    <= FETCH_ACCESS;
                        bus_as_  <= 1'b0;
                        bus_addr <= pc;
                        busy     <= 1'b1;
                    end
                end
                FETCH_ACCESS: begin
                    if (complete) begin
                        state   <= FETCH_REQ;
                        busy    <= 1'b0;
                        discard <= 1'b0;
`ifdef IF_INSN_BUF_EN
                        if (stall && !flush && !discard) begin
                            state    <= FETCH_HOLD;
                            bus_req_ <= 1'b1;
                        end
`endif
                    end else if (redirect) begin
                        // The access runs to completion; only its data is dropped.
                        discard <= 1'b1;
                    end
                end
`ifdef IF_INSN_BUF_EN
                FETCH_HOLD: begin
                    if (flush || !stall) begin
                        state    <= FETCH_REQ;
                        bus_req_ <= 1'b0;
                    end
                end
`endif
                default: state <= FETCH_REQ;
            endcase

            if (flush) begin
                pc      <= new_pc;
                if_en   <= 1'b0;
                if_insn <= NOP_INSN;
            end else if (stall) begin
`ifdef IF_INSN_BUF_EN
                if (complete && !discard) begin
                    buf_insn <= bus_rd_data;
                    pc       <= pc + 30'd1;
                end
`endif
            end else if (br_taken) begin
                pc      <= br_addr;
                if_en   <= 1'b0;
                if_insn <= NOP_INSN;
            end else if (complete && !discard) begin
                if_insn <= bus_rd_data;
                if_pc   <= pc + 30'd1;
                if_en   <= 1'b1;
                pc      <= pc + 30'd1;
`ifdef IF_INSN_BUF_EN
            end else if (state == FETCH_HOLD) begin
                // PC already advanced when the word was buffered.
                if_insn <= buf_insn;
                if_pc   <= pc;
                if_en   <= 1'b1;
`endif
            end else begin
                if_en   <= 1'b0;
                if_insn <= NOP_INSN;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed bench for if_fetch: a vector table for the zero-wait pipeline flow plus
// hand-written sequences for wait states, in-flight redirect and stall.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        flush;
    logic [29:0] new_pc;
    logic        br_taken;
    logic [29:0] br_addr;
    logic        bus_req_;
    logic        bus_grnt_;
    logic        bus_as_;
    logic        bus_rw;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_data;
    logic [31:0] bus_rd_data;
    logic        bus_rdy_;
    logic [29:0] if_pc;
    logic [31:0] if_insn;
    logic        if_en;
    logic        busy;

    int checks   = 0;
    int failures = 0;
    int wait_states = 0;
    int wcnt;

    always #5 clk = ~clk;

    if_fetch #(.RESET_VECTOR(30'h100)) dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .new_pc(new_pc),
        .br_taken(br_taken), .br_addr(br_addr), .bus_req_(bus_req_), .bus_grnt_(bus_grnt_),
        .bus_as_(bus_as_), .bus_rw(bus_rw), .bus_addr(bus_addr), .bus_wr_data(bus_wr_data),
        .bus_rd_data(bus_rd_data), .bus_rdy_(bus_rdy_), .if_pc(if_pc), .if_insn(if_insn),
        .if_en(if_en), .busy(busy)
    );

    function automatic logic [31:0] mem(input logic [29:0] a);
        return {2'b00, a} ^ 32'hA5A5_0101;
    endfunction

    // Slave: ready after wait_states cycles of an access, data is a function of address.
    always @(posedge clk) begin
        if (reset || !busy) wcnt <= 0;
        else                wcnt <= wcnt + 1;
    end
    assign bus_rdy_    = !(busy && (wcnt >= wait_states));
    assign bus_rd_data = mem(bus_addr);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall = 0; flush = 0; new_pc = '0; br_taken = 0; br_addr = '0; bus_grnt_ = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1;
        repeat (3) step();
        reset = 0;
    endtask

    typedef struct {
        logic        st;
        logic        fl;
        logic [29:0] npc;
        logic        br;
        logic [29:0] baddr;
        logic        en;
        logic [31:0] insn;
        logic [29:0] ipc;
        logic        as_n;
        logic [29:0] addr;
        logic        bsy;
    } vec_t;

    function automatic vec_t mk(input logic st, input logic fl, input logic [29:0] npc,
                                input logic br, input logic [29:0] baddr,
                                input logic en, input logic [31:0] insn, input logic [29:0] ipc,
                                input logic as_n, input logic [29:0] addr, input logic bsy);
        vec_t v;
        v.st = st; v.fl = fl; v.npc = npc; v.br = br; v.baddr = baddr;
        v.en = en; v.insn = insn; v.ipc = ipc; v.as_n = as_n; v.addr = addr; v.bsy = bsy;
        return v;
    endfunction

    vec_t vecs[15];

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int as_low, busy_cnt, en_cnt;
        bit seen;

        vecs[0]  = mk(0,0,30'h0,0,30'h0,         0, 32'h0,           30'h0,   0, 30'h100,      1);
        vecs[1]  = mk(0,0,30'h0,0,30'h0,         1, mem(30'h100),    30'h101, 1, 30'h100,      0);
        vecs[2]  = mk(0,0,30'h0,0,30'h0,         0, 32'h0,           30'h101, 0, 30'h101,      1);
        vecs[3]  = mk(0,0,30'h0,0,30'h0,         1, mem(30'h101),    30'h102, 1, 30'h101,      0);
        vecs[4]  = mk(0,1,30'h10,1,30'h20,       0, 32'h0,           30'h102, 1, 30'h101,      0);
        vecs[5]  = mk(0,0,30'h0,0,30'h0,         0, 32'h0,           30'h102, 0, 30'h10,       1);
        vecs[6]  = mk(0,0,30'h0,0,30'h0,         1, mem(30'h10),     30'h11,  1, 30'h10,       0);
        vecs[7]  = mk(0,0,30'h0,0,30'h0,         0, 32'h0,           30'h11,  0, 30'h11,       1);
        vecs[8]  = mk(0,0,30'h0,1,30'h40,        0, 32'h0,           30'h11,  1, 30'h11,       0);
        vecs[9]  = mk(0,0,30'h0,0,30'h0,         0, 32'h0,           30'h11,  0, 30'h40,       1);
        vecs[10] = mk(0,0,30'h0,0,30'h0,         1, mem(30'h40),     30'h41,  1, 30'h40,       0);
        vecs[11] = mk(0,1,30'h3FFF_FFFF,0,30'h0, 0, 32'h0,           30'h41,  1, 30'h40,       0);
        vecs[12] = mk(0,0,30'h0,0,30'h0,         0, 32'h0,           30'h41,  0, 30'h3FFF_FFFF,1);
        vecs[13] = mk(0,0,30'h0,0,30'h0,         1, mem(30'h3FFF_FFFF), 30'h0, 1, 30'h3FFF_FFFF,0);
        vecs[14] = mk(0,0,30'h0,0,30'h0,         0, 32'h0,           30'h0,   0, 30'h0,        1);

        // Reset state
        wait_states = 0;
        do_reset();
        check("rst_if_en",    if_en,       1'b0);
        check("rst_if_insn",  if_insn,     32'h0);
        check("rst_if_pc",    if_pc,       30'h0);
        check("rst_bus_req",  bus_req_,    1'b1);
        check("rst_bus_as",   bus_as_,     1'b1);
        check("rst_bus_addr", bus_addr,    30'h0);
        check("rst_busy",     busy,        1'b0);
        check("bus_rw",       bus_rw,      1'b1);
        check("bus_wr_data",  bus_wr_data, 32'h0);

        // Zero-wait table: flow, flush+branch priority, branch at completion, PC wrap
        for (int i = 0; i < 15; i++) begin
            stall = vecs[i].st; flush = vecs[i].fl; new_pc = vecs[i].npc;
            br_taken = vecs[i].br; br_addr = vecs[i].baddr;
            step();
            check($sformatf("v%0d_if_en", i),    if_en,    vecs[i].en);
            check($sformatf("v%0d_if_insn", i),  if_insn,  vecs[i].insn);
            check($sformatf("v%0d_if_pc", i),    if_pc,    vecs[i].ipc);
            check($sformatf("v%0d_bus_as", i),   bus_as_,  vecs[i].as_n);
            check($sformatf("v%0d_bus_addr", i), bus_addr, vecs[i].addr);
            check($sformatf("v%0d_busy", i),     busy,     vecs[i].bsy);
        end
        clear_inputs();

        // Three wait states: strobe for one cycle, busy for four, one completion
        wait_states = 3;
        do_reset();
        as_low = 0; busy_cnt = 0; en_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (!bus_as_) as_low++;
            if (busy) busy_cnt++;
            if (if_en) en_cnt++;
        end
        check("ws3_as_low_cycles", as_low, 1);
        check("ws3_busy_cycles", busy_cnt, 4);
        check("ws3_completions", en_cnt, 1);
        check("ws3_if_insn", if_insn, mem(30'h100));
        check("ws3_if_pc", if_pc, 30'h101);

        // Branch while an access is in flight: word dropped, next fetch at target
        do_reset();
        step();
        check("brmid_first_addr", bus_addr, 30'h100);
        br_taken = 1; br_addr = 30'h40;
        step();
        br_taken = 0;
        check("brmid_if_en", if_en, 1'b0);
        check("brmid_busy_held", busy, 1'b1);
        seen = 0;
        for (int i = 0; i < 12 && !seen; i++) begin
            step();
            if (if_en) begin
                check("brmid_discarded_en", if_en, 1'b0);
            end
            if (!bus_as_) begin
                seen = 1;
                check("brmid_next_addr", bus_addr, 30'h40);
            end
        end
        if (!seen) check("brmid_next_access_timeout", 1'b0, 1'b1);
        seen = 0;
        for (int i = 0; i < 8 && !seen; i++) begin
            step();
            if (if_en) seen = 1;
        end
        check("brmid_target_en", if_en, 1'b1);
        check("brmid_target_insn", if_insn, mem(30'h40));
        check("brmid_target_pc", if_pc, 30'h41);

        // Stall held five cycles across a completion
        wait_states = 0;
        do_reset();
        step();
        step();
        check("stall_pre_en", if_en, 1'b1);
        check("stall_pre_insn", if_insn, mem(30'h100));
        stall = 1;
        for (int i = 0; i < 5; i++) begin
            step();
            check($sformatf("stall%0d_if_en", i),   if_en,   1'b1);
            check($sformatf("stall%0d_if_insn", i), if_insn, mem(30'h100));
            check($sformatf("stall%0d_if_pc", i),   if_pc,   30'h101);
`ifdef IF_INSN_BUF_EN
            if (i >= 1) check($sformatf("stall%0d_hold_req", i), bus_req_, 1'b1);
`endif
        end
        stall = 0;
`ifdef IF_INSN_BUF_EN
        step();
        check("release_buf_en", if_en, 1'b1);
        check("release_buf_insn", if_insn, mem(30'h101));
        check("release_buf_pc", if_pc, 30'h102);
        step();
        check("release_next_addr", bus_addr, 30'h102);
`else
        seen = 0;
        for (int i = 0; i < 6 && !seen; i++) begin
            step();
            if (if_en) seen = 1;
        end
        check("release_refetch_en", if_en, 1'b1);
        check("release_refetch_insn", if_insn, mem(30'h101));
        check("release_refetch_pc", if_pc, 30'h102);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/if_fetch.md
# if_fetch

Instruction-fetch stage of the CPU pipeline, directly upstream of the instruction decoder. Owns the program counter, masters the bus to read one 32-bit instruction word per fetch, and drives the IF/ID pipeline register (`if_pc`, `if_insn`, `if_en`) that the decoder consumes. Redirects on pipeline flush and on the decoder's branch decision, and honours pipeline stall.

## Interface
- `RESET_VECTOR`, 30'h0000_0000: word address fetched first after reset.
- `NOP_INSN`, 32'h0000_0000: value driven on `if_insn` when the IF/ID register is invalidated.

Ports (clock and reset first):
- `clk` in 1: single clock, all state on rising edge.
- `reset` in 1: synchronous, active-high.
- `stall` in 1: hold IF/ID register and PC.
- `flush` in 1: redirect to `new_pc`, invalidate IF/ID.
- `new_pc` in 30: flush target word address.
- `br_taken` in 1: decoder branch taken.
- `br_addr` in 30: decoder branch target word address.
- `bus_req_` out 1: bus request, active-low.
- `bus_grnt_` in 1: bus grant, active-low.
- `bus_as_` out 1: address strobe, active-low.
- `bus_rw` out 1: always 1 (read).
- `bus_addr` out 30: fetch word address.
- `bus_wr_data` out 32: always 0.
- `bus_rd_data` in 32: fetched instruction.
- `bus_rdy_` in 1: slave ready, active-low.
- `if_pc` out 30: word address of the fetched instruction + 1.
- `if_insn` out 32: fetched instruction.
- `if_en` out 1: IF/ID contents valid.
- `busy` out 1: bus access outstanding (state `FETCH_ACCESS`).

## Operation
- FSM states:
  - `FETCH_REQ`: `bus_req_`=0. If `bus_grnt_`=0, go to `FETCH_ACCESS`.
  - `FETCH_ACCESS`: `bus_as_`=0 in the first cycle only. `bus_addr`=`pc` throughout. Wait for `bus_rdy_`=0, then go to `FETCH_REQ`.
  - `FETCH_HOLD`: only with the buffer feature (see Configuration).
- Completion (`bus_rdy_`=0 in `FETCH_ACCESS`, no discard pending, no stall):
  - `if_insn` <= `bus_rd_data`, `if_pc` <= `pc`+1, `if_en` <= 1.
  - `pc` <= `pc`+1, wrapping modulo 2^30.
- Cycles with no completion: `if_en` <= 0 and `if_insn` <= `NOP_INSN`, unless stalled.
- Priority per cycle: `reset` > `flush` > `stall` > `br_taken` > normal.
  - `flush`: `pc` <= `new_pc`; `if_en` <= 0; `if_insn` <= `NOP_INSN`.
  - `stall`: `pc`, `if_pc`, `if_insn` and `if_en` hold.
  - `br_taken` (no stall): `pc` <= `br_addr`; `if_en` <= 0.
- A started bus access is never aborted. If `flush` or `br_taken` arrives while in `FETCH_ACCESS`, set `discard`. The returning word is dropped, `discard` clears, and the next fetch uses the new `pc`.
- Completion during `stall` without the buffer feature: data dropped, `pc` unchanged, refetched after stall release.
- Reset values: `pc`=`RESET_VECTOR`, state `FETCH_REQ`, `discard`=0, `if_pc`=0, `if_insn`=`NOP_INSN`, `if_en`=0, `bus_req_`=1, `bus_as_`=1, `bus_addr`=0, `busy`=0.
- `reset` asserted mid-access overrides everything. The bus slave is expected to be reset in the same cycle.

## Timing
- All outputs are registered.
- Zero-wait slave with continuous grant:
  - cycle 0 `FETCH_REQ`;
  - cycle 1 `FETCH_ACCESS` with `bus_as_`=0 and `bus_rdy_`=0;
  - cycle 2 `if_en`=1.
- Throughput: one instruction every 2 cycles; each slave wait state adds 1 cycle.
- `br_taken`/`flush` at edge N: `if_en`=0 after edge N. The first target instruction is valid no earlier than edge N+2, plus the remaining cycles of any in-flight access.

## Configuration
- `IF_INSN_BUF_EN` defined: adds a one-entry buffer and the `FETCH_HOLD` state.
  - A completion during `stall` is captured into the buffer, `pc` advances, and the FSM enters `FETCH_HOLD` with no bus request.
  - On stall release the buffer loads IF/ID the same cycle and the FSM returns to `FETCH_REQ`.
  - `flush`/`br_taken` empties the buffer.
- `IF_INSN_BUF_EN` undefined: no buffer; completions during stall are dropped and refetched.

## Structure
- Shared package/header holds:
  - FSM state encodings: `FETCH_REQ`=2'd0, `FETCH_ACCESS`=2'd1, `FETCH_HOLD`=2'd2;
  - bus width constants and `READ`=1'b1;
  - the `NOP_INSN` default.
- No sub-module: the FSM, PC and IF/ID register sit in one module.

## Test plan
- Reset with `RESET_VECTOR`=30'h100, zero-wait slave returning 32'hA5A5_0001 -> `bus_addr`=30'h100 and `bus_as_`=0 at cycle 1; at cycle 2 `if_en`=1, `if_insn`=32'hA5A5_0001, `if_pc`=30'h101.
- Slave with 3 wait states -> `bus_as_` low for 1 cycle only; `busy`=1 for 4 cycles; one completion.
- `br_taken`=1 with `br_addr`=30'h40 mid-access -> in-flight word discarded, `if_en`=0, next `bus_addr`=30'h40.
- `flush` and `br_taken` in the same cycle (`new_pc`=30'h10, `br_addr`=30'h20) -> next fetch from 30'h10.
- `stall` held 5 cycles across a completion -> IF/ID unchanged during the stall.
  - With `IF_INSN_BUF_EN`: buffered word appears the cycle after release.
  - Without it: same address refetched.
- `pc`=30'h3FFF_FFFF -> `if_pc`=0 and next fetch at address 0.
